// File: rtl/lsu_perf_tracker_if.sv
// rtl/lsu_perf_tracker_if.sv - fetch and LSU fire strobes observed by the perf tracker
interface lsu_perf_tracker_if #(
  parameter int NUM_LANES  = 4,
  parameter int ADDR_WIDTH = 30
);
  logic                            icache_req_fire;
  logic                            icache_rsp_fire;
  logic                            lsu_req_fire;
  logic                            lsu_req_rw;
  logic [NUM_LANES-1:0]            lsu_req_mask;
  logic [NUM_LANES*ADDR_WIDTH-1:0] lsu_req_addr;
  logic                            lsu_rsp_fire;

  // core side drives the strobes
  modport master (
    output icache_req_fire, icache_rsp_fire, lsu_req_fire, lsu_req_rw,
           lsu_req_mask, lsu_req_addr, lsu_rsp_fire
  );

  // tracker only observes
  modport slave (
    input icache_req_fire, icache_rsp_fire, lsu_req_fire, lsu_req_rw,
          lsu_req_mask, lsu_req_addr, lsu_rsp_fire
  );
endinterface

// File: rtl/lsu_perf_tracker.sv
// rtl/lsu_perf_tracker.sv - fetch/memory event counters and outstanding-cycle accumulators
module lsu_perf_tracker #(
  parameter int NUM_LANES     = 4,
  parameter int ADDR_WIDTH    = 30,
  parameter int PERF_CTR_BITS = 44,
  parameter int PENDING_BITS  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  lsu_perf_tracker_if.slave        bus,
  output logic [PERF_CTR_BITS-1:0] ifetches,
  output logic [PERF_CTR_BITS-1:0] loads,
  output logic [PERF_CTR_BITS-1:0] stores,
  output logic [PERF_CTR_BITS-1:0] ifetch_latency,
  output logic [PERF_CTR_BITS-1:0] load_latency,
  output logic [PERF_CTR_BITS-1:0] same_address,
  output logic [PENDING_BITS-1:0]  ifetch_pending,
  output logic [PENDING_BITS-1:0]  load_pending
);

  logic                  req_valid;
  logic                  load_req;
  logic                  store_req;
  logic                  same_addr;
  logic                  lead_found;
  logic                  multi_lane;
  logic                  all_match;
  logic [ADDR_WIDTH-1:0] lead_addr;
  logic [ADDR_WIDTH-1:0] lane_addr [NUM_LANES];

  // a request with no active lanes is not an event at all
  assign req_valid = bus.lsu_req_fire && (bus.lsu_req_mask != '0);
  assign load_req  = req_valid && !bus.lsu_req_rw;
  assign store_req = req_valid && bus.lsu_req_rw;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_addr[i] = bus.lsu_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // compare every active lane against the lowest-index active lane
  always_comb begin
    lead_addr  = '0;
    lead_found = 1'b0;
    multi_lane = 1'b0;
    all_match  = 1'b1;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (bus.lsu_req_mask[i]) begin
        if (!lead_found) begin
          lead_addr  = lane_addr[i];
          lead_found = 1'b1;
        end else begin
          multi_lane = 1'b1;
          if (lane_addr[i] != lead_addr) all_match = 1'b0;
        end
      end
    end
    same_addr = req_valid && multi_lane && all_match;
  end

  // +1/-1 with saturation at both ends; simultaneous inc and dec cancel
  function automatic logic [PENDING_BITS-1:0] pend_next(
    input logic [PENDING_BITS-1:0] cur,
    input logic                    inc,
    input logic                    dec
  );
    pend_next = cur;
    if (inc && !dec && (cur != '1)) pend_next = cur + PENDING_BITS'(1);
    else if (dec && !inc && (cur != '0)) pend_next = cur - PENDING_BITS'(1);
  endfunction

  // outstanding-request counters, unaffected by clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifetch_pending <= '0;
      load_pending   <= '0;
    end else begin
      ifetch_pending <= pend_next(ifetch_pending, bus.icache_req_fire, bus.icache_rsp_fire);
      load_pending   <= pend_next(load_pending, load_req, bus.lsu_rsp_fire);
    end
  end

  // event counts and latency totals; latency adds the pre-update pending value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifetches       <= '0;
      loads          <= '0;
      stores         <= '0;
      ifetch_latency <= '0;
      load_latency   <= '0;
      same_address   <= '0;
    end else if (clear) begin
      ifetches       <= '0;
      loads          <= '0;
      stores         <= '0;
      ifetch_latency <= '0;
      load_latency   <= '0;
      same_address   <= '0;
    end else begin
      ifetches       <= ifetches + PERF_CTR_BITS'(bus.icache_req_fire);
      loads          <= loads + PERF_CTR_BITS'(load_req);
      stores         <= stores + PERF_CTR_BITS'(store_req);
      ifetch_latency <= ifetch_latency + PERF_CTR_BITS'(ifetch_pending);
      load_latency   <= load_latency + PERF_CTR_BITS'(load_pending);
      same_address   <= same_address + PERF_CTR_BITS'(same_addr);
    end
  end

  // flag a response that arrives with nothing outstanding
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.icache_rsp_fire && !bus.icache_req_fire && (ifetch_pending == '0)))
        else $warning("ifetch response with no outstanding request");
      assert (!(bus.lsu_rsp_fire && !load_req && (load_pending == '0)))
        else $warning("load response with no outstanding request");
    end
  end

endmodule

// File: tb/tb_lsu_perf_tracker.sv
// tb/tb_lsu_perf_tracker.sv - randomized and directed checks of lsu_perf_tracker against a reference model
module tb_lsu_perf_tracker;
  localparam int NL = 4;
  localparam int AW = 30;
  localparam int CB = 44;
  localparam int PB = 8;
  localparam longint unsigned CMASK = (64'd1 << CB) - 64'd1;
  localparam int PMAX = (1 << PB) - 1;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  logic [CB-1:0] ifetches, loads, stores, ifetch_latency, load_latency, same_address;
  logic [PB-1:0] ifetch_pending, load_pending;

  int checks = 0;
  int failures = 0;

  longint unsigned m_if, m_ld, m_st, m_ifl, m_ldl, m_sa;
  int m_ifp, m_ldp;

  always #5 clk = ~clk;

  lsu_perf_tracker_if #(.NUM_LANES(NL), .ADDR_WIDTH(AW)) bus ();

  lsu_perf_tracker #(
    .NUM_LANES(NL), .ADDR_WIDTH(AW), .PERF_CTR_BITS(CB), .PENDING_BITS(PB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .bus(bus.slave),
    .ifetches(ifetches),
    .loads(loads),
    .stores(stores),
    .ifetch_latency(ifetch_latency),
    .load_latency(load_latency),
    .same_address(same_address),
    .ifetch_pending(ifetch_pending),
    .load_pending(load_pending)
  );

  task automatic idle_inputs();
    clear                = 1'b0;
    bus.icache_req_fire  = 1'b0;
    bus.icache_rsp_fire  = 1'b0;
    bus.lsu_req_fire     = 1'b0;
    bus.lsu_req_rw       = 1'b0;
    bus.lsu_req_mask     = '0;
    bus.lsu_req_addr     = '0;
    bus.lsu_rsp_fire     = 1'b0;
  endtask

  task automatic model_zero();
    m_if = 0; m_ld = 0; m_st = 0; m_ifl = 0; m_ldl = 0; m_sa = 0;
    m_ifp = 0; m_ldp = 0;
  endtask

  // next state from the rules: counts of events, sums of outstanding requests
  task automatic model_step();
    bit valid, same;
    logic [AW-1:0] first, a;
    int n, p;
    valid = bus.lsu_req_fire && (bus.lsu_req_mask != '0);
    same = 1; n = 0; first = '0;
    for (int i = 0; i < NL; i++) begin
      if (bus.lsu_req_mask[i]) begin
        a = bus.lsu_req_addr[i*AW +: AW];
        if (n == 0) first = a;
        else if (a != first) same = 0;
        n++;
      end
    end
    same = valid && same && (n >= 2);
    if (clear) begin
      m_if = 0; m_ld = 0; m_st = 0; m_ifl = 0; m_ldl = 0; m_sa = 0;
    end else begin
      m_if  = (m_if + (bus.icache_req_fire ? 1 : 0)) & CMASK;
      m_ld  = (m_ld + ((valid && !bus.lsu_req_rw) ? 1 : 0)) & CMASK;
      m_st  = (m_st + ((valid && bus.lsu_req_rw) ? 1 : 0)) & CMASK;
      m_sa  = (m_sa + (same ? 1 : 0)) & CMASK;
      m_ifl = (m_ifl + longint'(m_ifp)) & CMASK;
      m_ldl = (m_ldl + longint'(m_ldp)) & CMASK;
    end
    p = m_ifp + (bus.icache_req_fire ? 1 : 0) - (bus.icache_rsp_fire ? 1 : 0);
    m_ifp = (p < 0) ? 0 : (p > PMAX) ? PMAX : p;
    p = m_ldp + ((valid && !bus.lsu_req_rw) ? 1 : 0) - (bus.lsu_rsp_fire ? 1 : 0);
    m_ldp = (p < 0) ? 0 : (p > PMAX) ? PMAX : p;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    model_zero();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    model_zero();
    #2;
    checks++;
    if ({ifetches, loads, stores, ifetch_latency, load_latency, same_address, ifetch_pending, load_pending} !== '0) begin
      failures++;
      $display("FAIL reset_async: got nonzero outputs ifetches=%0d loads=%0d ifp=%0d, expected all 0", ifetches, loads, ifetch_pending);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if ({ifetches, loads, stores, ifetch_latency, load_latency, same_address, ifetch_pending, load_pending} !== '0) begin
      failures++;
      $display("FAIL reset_idle: got nonzero outputs ifl=%0d ldl=%0d sa=%0d, expected all 0", ifetch_latency, load_latency, same_address);
    end
  endtask

  task automatic test_single_load();
    do_reset();
    bus.lsu_req_fire = 1'b1; bus.lsu_req_rw = 1'b0; bus.lsu_req_mask = 4'b0001;
    tick();
    idle_inputs();
    checks++;
    if (loads !== 44'd1 || load_pending !== 8'd1) begin
      failures++;
      $display("FAIL single_load_issue: loads=%0d pending=%0d, expected 1 and 1", loads, load_pending);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (load_pending !== 8'd1) begin
        failures++;
        $display("FAIL single_load_pending: cycle %0d pending=%0d, expected 1", i + 2, load_pending);
      end
    end
    bus.lsu_rsp_fire = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (load_latency !== 44'd5 || load_pending !== 8'd0) begin
      failures++;
      $display("FAIL single_load_latency: latency=%0d pending=%0d, expected 5 and 0", load_latency, load_pending);
    end
  endtask

  task automatic test_overlap();
    do_reset();
    for (int t = 0; t < 8; t++) begin
      idle_inputs();
      if (t == 0 || t == 2) begin
        bus.lsu_req_fire = 1'b1; bus.lsu_req_mask = 4'b0011;
      end
      if (t == 4 || t == 7) bus.lsu_rsp_fire = 1'b1;
      tick();
    end
    idle_inputs();
    checks++;
    if (load_latency !== 44'd9 || load_pending !== 8'd0 || loads !== 44'd2) begin
      failures++;
      $display("FAIL overlap_loads: latency=%0d pending=%0d loads=%0d, expected 9 0 2", load_latency, load_pending, loads);
    end
  endtask

  task automatic test_same_address();
    do_reset();
    bus.lsu_req_fire = 1'b1; bus.lsu_req_rw = 1'b1; bus.lsu_req_mask = 4'b1011;
    bus.lsu_req_addr = {30'h100, 30'h200, 30'h100, 30'h100};
    tick();
    checks++;
    if (stores !== 44'd1 || same_address !== 44'd1 || load_pending !== 8'd0) begin
      failures++;
      $display("FAIL same_addr_store: stores=%0d same=%0d pending=%0d, expected 1 1 0", stores, same_address, load_pending);
    end
    bus.lsu_req_mask = 4'b0100;
    tick();
    checks++;
    if (stores !== 44'd2 || same_address !== 44'd1) begin
      failures++;
      $display("FAIL same_addr_single_lane: stores=%0d same=%0d, expected 2 1", stores, same_address);
    end
    bus.lsu_req_rw = 1'b0; bus.lsu_req_mask = 4'b0000;
    tick();
    bus.lsu_req_mask = 4'b0110;
    tick();
    idle_inputs();
    checks++;
    if (loads !== 44'd1 || same_address !== 44'd1 || load_pending !== 8'd1) begin
      failures++;
      $display("FAIL mask0_and_diff_addr: loads=%0d same=%0d pending=%0d, expected 1 1 1", loads, same_address, load_pending);
    end
  endtask

  task automatic test_clear();
    do_reset();
    bus.icache_req_fire = 1'b1;
    tick();
    tick();
    clear = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (ifetches !== 44'd0 || ifetch_pending !== 8'd3 || ifetch_latency !== 44'd0) begin
      failures++;
      $display("FAIL clear_beats_inc: ifetches=%0d pending=%0d latency=%0d, expected 0 3 0", ifetches, ifetch_pending, ifetch_latency);
    end
    tick();
    tick();
    checks++;
    if (ifetch_latency !== 44'd6) begin
      failures++;
      $display("FAIL clear_resume: latency=%0d, expected 6", ifetch_latency);
    end
  endtask

  task automatic test_wrap_underflow();
    do_reset();
    bus.icache_req_fire = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    idle_inputs();
    force dut.ifetch_latency = 44'hFFF_FFFF_FFFE;
    #1;
    release dut.ifetch_latency;
    m_ifl = 64'h0000_0FFF_FFFF_FFFE;
    tick();
    checks++;
    if (ifetch_latency !== 44'd1) begin
      failures++;
      $display("FAIL latency_wrap: latency=%0d, expected 1", ifetch_latency);
    end
    bus.icache_rsp_fire = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    idle_inputs();
    checks++;
    if (ifetch_pending !== 8'd0 || ifetch_latency !== 44'd7) begin
      failures++;
      $display("FAIL pending_hold_zero: pending=%0d latency=%0d, expected 0 7", ifetch_pending, ifetch_latency);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      idle_inputs();
      clear               = ($urandom_range(0, 39) == 0);
      bus.icache_req_fire = ($urandom_range(0, 2) == 0);
      bus.icache_rsp_fire = (m_ifp > 0) && ($urandom_range(0, 2) == 0);
      bus.lsu_req_fire    = ($urandom_range(0, 1) == 0);
      bus.lsu_req_rw      = ($urandom_range(0, 2) == 0);
      bus.lsu_req_mask    = 4'($urandom_range(0, 15));
      for (int i = 0; i < NL; i++)
        bus.lsu_req_addr[i*AW +: AW] = ($urandom_range(0, 2) == 0) ? 30'h104 : 30'h100;
      bus.lsu_rsp_fire    = (m_ldp > 0) && ($urandom_range(0, 2) == 0);
      tick();
      checks++;
      if (ifetches !== m_if[CB-1:0] || loads !== m_ld[CB-1:0] || stores !== m_st[CB-1:0] ||
          ifetch_latency !== m_ifl[CB-1:0] || load_latency !== m_ldl[CB-1:0] ||
          same_address !== m_sa[CB-1:0] || ifetch_pending !== PB'(m_ifp) || load_pending !== PB'(m_ldp)) begin
        failures++;
        $display("FAIL random_c%0d: got if=%0d ld=%0d st=%0d ifl=%0d ldl=%0d sa=%0d ifp=%0d ldp=%0d expected %0d %0d %0d %0d %0d %0d %0d %0d",
                 c, ifetches, loads, stores, ifetch_latency, load_latency, same_address, ifetch_pending, load_pending,
                 m_if, m_ld, m_st, m_ifl, m_ldl, m_sa, m_ifp, m_ldp);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    model_zero();
    test_reset();
    test_single_load();
    test_overlap();
    test_same_address();
    test_clear();
    test_wrap_underflow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
